conf_cmd_dispatch: RTL and testbench
====================================

CONF_CMD_DISPATCH -- requirements
Module: conf_cmd_dispatch

Interface
REQ-001 SHALL have parameter STAGE_NUM, default 8, number of downstream parser stages with a rule-configuration port.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the completed-command counter.
REQ-003 i_clk  input  1  clock; all logic on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_cmd_valid  input  1  command word valid.
REQ-006 i_cmd_data  input  32  command word.
REQ-007 i_cmd_last  input  1  final word of the command.
REQ-008 o_cmd_ready  output  1  word accepted when i_cmd_valid and o_cmd_ready are both high.
REQ-009 o_rule_wren  output  STAGE_NUM  one-hot per-stage rule write strobe.
REQ-010 o_rule_addr  output  32  rule address, shared by all stages.
REQ-011 o_rule_wdata  output  32  rule data, shared by all stages.
REQ-012 o_err  output  1  one-cycle pulse on a malformed command.
REQ-013 o_busy  output  1  high whenever state is not IDLE.
REQ-014 o_cmd_cnt  output  CNT_WIDTH  count of commands completed without error; saturates at all-ones.

Function
REQ-015 Header word format: [31:28] opcode, [27:24] stage id, [23:16] length N, [15:0] base address.
REQ-016 Opcode 4'h1 (WRITE) is the only legal opcode.
REQ-017 State machine: IDLE, DATA, DROP.
REQ-018 o_cmd_ready SHALL be 1 in every state after reset; the block never backpressures.
REQ-019 IDLE, legal header accepted, N>0, stage id < STAGE_NUM, last=0: latch stage, base and N; clear word index; go to DATA.
REQ-020 IDLE, header with bad opcode, stage id >= STAGE_NUM or N=0: pulse o_err; go to DROP if last=0, else stay IDLE.
REQ-021 IDLE, legal header with last=1: pulse o_err; stay IDLE.
REQ-022 DATA, each accepted word k (0-based): next cycle o_rule_wren[stage]=1, o_rule_addr={16'b0, (base+k) mod 2^16}, o_rule_wdata=word.
REQ-023 Write latency is exactly 1 cycle from word acceptance; at most one write per cycle.
REQ-024 DATA, word k=N-1 with last=1: issue the write; increment o_cmd_cnt; go to IDLE.
REQ-025 DATA, last=1 with k<N-1: issue the write; pulse o_err; go to IDLE; o_cmd_cnt unchanged.
REQ-026 DATA, k=N-1 with last=0: issue the write; pulse o_err; go to DROP.
REQ-027 DROP: discard words without writing; go to IDLE on an accepted word with last=1.
REQ-028 o_rule_wren SHALL be 0 in any cycle without a write; addr and data SHALL hold their last values.
REQ-029 Address wraps within 16 bits (base 16'hFFFF, k=1 gives addr 0); the upper 16 bits are always 0.
REQ-030 A word index counter of 8 bits SHALL compare against N-1.
REQ-031 o_err and a write strobe MAY assert in the same cycle (REQ-025, REQ-026).

Reset
REQ-032 Asynchronous reset SHALL set state IDLE, o_rule_wren=0, o_err=0, o_busy=0 and o_cmd_cnt=0.
REQ-033 Asynchronous reset SHALL set o_rule_addr=0 and o_rule_wdata=0.
REQ-034 Reset mid-command SHALL abandon the command with no further writes; the next word after reset is parsed as a header.

Structure
REQ-035 Opcode constant, header field bit-ranges and the state enum SHALL live in parser_pkg beside the existing rule-address field macros.
REQ-036 No sub-module: a single FSM plus output registers.
REQ-037 o_rule_wren/addr/wdata SHALL connect directly to the rule_wren/addr/wdata inputs of each stage's rule-configuration block.

Verification
REQ-038 Header 0x1_2_03_0100, then words A,B,C with last on C -> wren[2] on 3 cycles, addr 0x100/0x101/0x102, data A/B/C, cnt=1, err=0.
REQ-039 Header base 0xFFFF, N=2 -> addrs 0xFFFF then 0x0000.
REQ-040 Header opcode 0x3, followed by 4 words with last on word 4 -> no wren, one err pulse, back to IDLE, the next legal command executes.
REQ-041 N=4 with last on data word 2 -> 2 writes, err pulse on the 2nd write's acceptance, cnt unchanged.
REQ-042 Stage id 9 with STAGE_NUM=8 -> err, DROP until last, no writes.
REQ-043 Assert i_rst_n low after data word 1 of N=3 -> outputs cleared, no further writes; the following header is decoded correctly.

Source files
------------

// File: rtl/parser_pkg.sv
// ============================================================================
// parser_pkg : shared parser constants, command header fields, dispatch FSM
// Revision   : 1.0
// ============================================================================
`default_nettype none

package parser_pkg;

  localparam logic [3:0] c_op_write = 4'h1;

  // Command header layout: [31:28] opcode, [27:24] stage, [23:16] length, [15:0] base
  localparam int c_hdr_op_msb    = 31;
  localparam int c_hdr_op_lsb    = 28;
  localparam int c_hdr_stage_msb = 27;
  localparam int c_hdr_stage_lsb = 24;
  localparam int c_hdr_len_msb   = 23;
  localparam int c_hdr_len_lsb   = 16;
  localparam int c_hdr_base_msb  = 15;
  localparam int c_hdr_base_lsb  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } cmd_state_e;

  function automatic logic [3:0] hdr_op(input logic [31:0] w);
    return w[c_hdr_op_msb:c_hdr_op_lsb];
  endfunction

  function automatic logic [3:0] hdr_stage(input logic [31:0] w);
    return w[c_hdr_stage_msb:c_hdr_stage_lsb];
  endfunction

  function automatic logic [7:0] hdr_len(input logic [31:0] w);
    return w[c_hdr_len_msb:c_hdr_len_lsb];
  endfunction

  function automatic logic [15:0] hdr_base(input logic [31:0] w);
    return w[c_hdr_base_msb:c_hdr_base_lsb];
  endfunction

endpackage

`default_nettype wire

// File: rtl/conf_cmd_dispatch.sv
// ============================================================================
// conf_cmd_dispatch : decodes configuration commands into per-stage rule writes
// Revision          : 1.0
// ============================================================================
`default_nettype none

module conf_cmd_dispatch
  import parser_pkg::*;
#(
  parameter int STAGE_NUM = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_valid,
  input  logic [31:0]          i_cmd_data,
  input  logic                 i_cmd_last,
  output logic                 o_cmd_ready,
  output logic [STAGE_NUM-1:0] o_rule_wren,
  output logic [31:0]          o_rule_addr,
  output logic [31:0]          o_rule_wdata,
  output logic                 o_err,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_cmd_cnt
);

  cmd_state_e           state_q, state_d;
  logic [3:0]           stage_q, stage_d;
  logic [15:0]          base_q,  base_d;
  logic [7:0]           len_q,   len_d;
  logic [7:0]           idx_q,   idx_d;
  logic [STAGE_NUM-1:0] wren_q,  wren_d;
  logic [31:0]          addr_q,  addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 err_q,   err_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

  logic hdr_legal;
  logic last_idx;

  assign hdr_legal = (hdr_op(i_cmd_data) == c_op_write) &&
                     ({28'd0, hdr_stage(i_cmd_data)} < STAGE_NUM) &&
                     (hdr_len(i_cmd_data) != 8'd0);
  assign last_idx  = (idx_q == len_q - 8'd1);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wren_d  = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          if (hdr_legal && !i_cmd_last) begin
            stage_d = hdr_stage(i_cmd_data);
            base_d  = hdr_base(i_cmd_data);
            len_d   = hdr_len(i_cmd_data);
            idx_d   = 8'd0;
            state_d = ST_DATA;
          end else begin
            err_d = 1'b1;
            if (!hdr_legal && !i_cmd_last) state_d = ST_DROP;
          end
        end
      end

      ST_DATA: begin
        if (i_cmd_valid) begin
          for (int s = 0; s < STAGE_NUM; s++) begin
            if (stage_q == 4'(s)) wren_d[s] = 1'b1;
          end
          addr_d  = {16'd0, base_q + {8'd0, idx_q}};
          wdata_d = i_cmd_data;
          idx_d   = idx_q + 8'd1;
          if (i_cmd_last && last_idx) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            state_d = ST_IDLE;
          end else if (i_cmd_last) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (last_idx) begin
            // Command longer than its declared length: drop the surplus
            err_d   = 1'b1;
            state_d = ST_DROP;
          end
        end
      end

      ST_DROP: begin
        if (i_cmd_valid && i_cmd_last) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= 4'd0;
      base_q  <= 16'd0;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      wren_q  <= '0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_cmd_ready  = 1'b1;
  assign o_rule_wren  = wren_q;
  assign o_rule_addr  = addr_q;
  assign o_rule_wdata = wdata_q;
  assign o_err        = err_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_cmd_cnt    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_conf_cmd_dispatch.sv
// ============================================================================
// tb_conf_cmd_dispatch : command-level model bench for conf_cmd_dispatch
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_conf_cmd_dispatch;

  localparam int SN = 8;
  localparam int CW = 3;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_cmd_valid;
  logic [31:0]   i_cmd_data;
  logic          i_cmd_last;
  logic          o_cmd_ready;
  logic [SN-1:0] o_rule_wren;
  logic [31:0]   o_rule_addr;
  logic [31:0]   o_rule_wdata;
  logic          o_err;
  logic          o_busy;
  logic [CW-1:0] o_cmd_cnt;

  always #5 i_clk = ~i_clk;

  conf_cmd_dispatch #(.STAGE_NUM(SN), .CNT_WIDTH(CW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_cmd_valid  (i_cmd_valid),
    .i_cmd_data   (i_cmd_data),
    .i_cmd_last   (i_cmd_last),
    .o_cmd_ready  (o_cmd_ready),
    .o_rule_wren  (o_rule_wren),
    .o_rule_addr  (o_rule_addr),
    .o_rule_wdata (o_rule_wdata),
    .o_err        (o_err),
    .o_busy       (o_busy),
    .o_cmd_cnt    (o_cmd_cnt)
  );

  int checks   = 0;
  int failures = 0;

  logic [SN-1:0] m_wren  = '0;
  logic [31:0]   m_addr  = '0;
  logic [31:0]   m_wdata = '0;
  logic          m_err   = 1'b0;
  logic          m_busy  = 1'b0;
  logic [CW-1:0] m_cnt   = '0;
  logic          chk_en  = 1'b0;

  logic [31:0] cw [0:15];
  int          cn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("ready", {31'd0, o_cmd_ready}, 32'd1);
      chk("wren",  {{(32-SN){1'b0}}, o_rule_wren}, {{(32-SN){1'b0}}, m_wren});
      chk("addr",  o_rule_addr, m_addr);
      chk("wdata", o_rule_wdata, m_wdata);
      chk("err",   {31'd0, o_err}, {31'd0, m_err});
      chk("busy",  {31'd0, o_busy}, {31'd0, m_busy});
      chk("cnt",   {{(32-CW){1'b0}}, o_cmd_cnt}, {{(32-CW){1'b0}}, m_cnt});
    end
  end

  // Whole-command model: a legal header with nd data words writes the first
  // min(N, nd) words; exactly one err pulse unless nd == N; term=0 leaves the
  // command open (no last on the final word driven).
  task automatic run_cmd(input bit term);
    logic [3:0] op, st;
    int         n_len, base, nd, lim, k;
    logic       legal;
    op    = cw[0][31:28];
    st    = cw[0][27:24];
    n_len = int'(cw[0][23:16]);
    base  = int'(cw[0][15:0]);
    legal = (op == 4'h1) && (int'(st) < SN) && (n_len != 0);
    nd    = cn - 1;
    lim   = (term && nd < n_len) ? nd : n_len;
    for (int j = 0; j < cn; j++) begin
      i_cmd_valid = 1'b1;
      i_cmd_data  = cw[j];
      i_cmd_last  = term && (j == cn - 1);
      @(posedge i_clk);
      #1;
      m_wren = '0;
      m_err  = 1'b0;
      if (j == 0) begin
        m_err = !legal || (nd == 0 && term);
      end else if (legal) begin
        k = j - 1;
        if (k < lim) begin
          m_wren  = SN'(1) << st;
          m_addr  = {16'd0, 16'(base + k)};
          m_wdata = cw[j];
        end
        if (k == lim - 1 && !(term && nd == n_len)) m_err = 1'b1;
        if (term && k == nd - 1 && nd == n_len && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      end
      m_busy = !(term && j == cn - 1);
    end
    i_cmd_valid = 1'b0;
    i_cmd_last  = 1'b0;
    i_cmd_data  = 32'd0;
    @(posedge i_clk);
    #1;
    m_wren = '0;
    m_err  = 1'b0;
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_data  = 32'd0;
    i_cmd_last  = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Basic 3-word write to stage 2
    cw[0] = 32'h1203_0100; cw[1] = 32'hAAAA_0001; cw[2] = 32'hBBBB_0002; cw[3] = 32'hCCCC_0003;
    cn = 4; run_cmd(1'b1);
    chk("lit_cnt_basic",  {29'd0, o_cmd_cnt}, 32'd1);
    chk("lit_addr_basic", o_rule_addr, 32'h0000_0102);
    chk("lit_data_basic", o_rule_wdata, 32'hCCCC_0003);

    // Address wrap at 16 bits
    cw[0] = 32'h1502_FFFF; cw[1] = 32'h1111_1111; cw[2] = 32'h2222_2222;
    cn = 3; run_cmd(1'b1);
    chk("lit_addr_wrap", o_rule_addr, 32'h0000_0000);

    // Bad opcode then 4 dropped words, then a legal command
    cw[0] = 32'h3104_0010; cw[1] = 32'h1; cw[2] = 32'h2; cw[3] = 32'h3; cw[4] = 32'h4;
    cn = 5; run_cmd(1'b1);
    cw[0] = 32'h1001_0020; cw[1] = 32'hDEAD_BEEF;
    cn = 2; run_cmd(1'b1);
    chk("lit_cnt_after_drop", {29'd0, o_cmd_cnt}, 32'd3);

    // Short command: N=4, last on data word 2
    cw[0] = 32'h1404_0200; cw[1] = 32'h5555_0000; cw[2] = 32'h6666_0000;
    cn = 3; run_cmd(1'b1);
    chk("lit_cnt_short", {29'd0, o_cmd_cnt}, 32'd3);

    // Stage id out of range
    cw[0] = 32'h1902_0000; cw[1] = 32'h7; cw[2] = 32'h8;
    cn = 3; run_cmd(1'b1);

    // Zero length, legal header with last, over-long command
    cw[0] = 32'h1100_0030; cw[1] = 32'h9;
    cn = 2; run_cmd(1'b1);
    cw[0] = 32'h1102_0030;
    cn = 1; run_cmd(1'b1);
    cw[0] = 32'h1602_0040; cw[1] = 32'hA; cw[2] = 32'hB; cw[3] = 32'hC;
    cn = 4; run_cmd(1'b1);
    chk("lit_cnt_errs", {29'd0, o_cmd_cnt}, 32'd3);

    // Reset in the middle of an N=3 command
    cw[0] = 32'h1303_0040; cw[1] = 32'h1234_5678;
    cn = 2; run_cmd(1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    m_wren = '0; m_addr = '0; m_wdata = '0; m_err = 1'b0; m_busy = 1'b0; m_cnt = '0;
    chk("lit_rst_addr", o_rule_addr, 32'd0);
    repeat (2) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    cw[0] = 32'h1101_0077; cw[1] = 32'h8765_4321;
    cn = 2; run_cmd(1'b1);
    chk("lit_addr_post_rst", o_rule_addr, 32'h0000_0077);
    chk("lit_wren_hold", {24'd0, o_rule_wren}, 32'd0);

    // Counter saturation, alternating edge stages 0 and 7
    for (int i = 0; i < 8; i++) begin
      cw[0] = (i % 2 == 0) ? 32'h1701_0000 : 32'h1001_0000;
      cw[0][15:0] = 16'(i);
      cw[1] = 32'hF000_0000 | 32'(i);
      cn = 2; run_cmd(1'b1);
    end
    chk("lit_cnt_sat", {29'd0, o_cmd_cnt}, 32'd7);

    repeat (2) @(posedge i_clk);
    #1 chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
